// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, LFSR taps and parameter sanity check for the PUF sequencer
package puf_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_SETTLE, S_SAMPLE, S_GAP, S_VOTE, S_DONE
  } state_t;
  function automatic logic [31:0] taps(input int w);
    return w == 8 ? 32'h0000_00B8 : w == 16 ? 32'h0000_B400 : 32'hA300_0000;
  endfunction
  function automatic bit params_ok(input int chal_w, input int num_eval, input int settle_cyc);
    return (chal_w == 8 || chal_w == 16 || chal_w == 32) && num_eval >= 1 &&
           num_eval % 2 == 1 && settle_cyc >= 1;
  endfunction
endpackage

// File: rtl/puf_eval_ctrl_lfsr.sv
// puf_lfsr: Galois right-shift LFSR with synchronous load and step
// ports: clk, rst_n (async, active low); load_i/seed_i load a seed; step_i advances; lfsr_o current word
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] lfsr_o
);
  localparam logic [W-1:0] TAPS = W'(taps(W));
  logic [W-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load_i ? seed_i : step_i ? (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0) : lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= '0;
    else lfsr_q <= lfsr_d;
  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: arbiter-PUF evaluation sequencer with per-bit majority voting
// ports: clk, rst_n (async, active low); ena (low aborts); start/challenge_in request a response;
//   race_launch/race_challenge drive the race core, race_bit returns its arbiter decision;
//   busy/done status, response (voted bits, LSB first), unstable_cnt (bits with disagreeing samples)
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CHAL_W     = 8,
  parameter int RESP_W     = 8,
  parameter int NUM_EVAL   = 5,
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        start,
  input  logic [CHAL_W-1:0]           challenge_in,
  output logic                        race_launch,
  output logic [CHAL_W-1:0]           race_challenge,
  input  logic                        race_bit,
  output logic                        busy,
  output logic                        done,
  output logic [RESP_W-1:0]           response,
  output logic [$clog2(RESP_W+1)-1:0] unstable_cnt
);
  localparam int EW = $clog2(NUM_EVAL + 1);
  localparam int UW = $clog2(RESP_W + 1);
  localparam int IW = RESP_W > 1 ? $clog2(RESP_W) : 1;
  localparam int CW = $clog2((SETTLE_CYC > GAP_CYC ? SETTLE_CYC : GAP_CYC) + 1);
  if (!params_ok(CHAL_W, NUM_EVAL, SETTLE_CYC)) begin : g_bad_params
    $error("puf_eval_ctrl: illegal CHAL_W/NUM_EVAL/SETTLE_CYC");
  end
  state_t        state_q;
  logic [CW-1:0] cyc_q;
  logic [EW-1:0] eval_q, ones_q;
  logic [IW-1:0] idx_q;
  logic          lfsr_load, lfsr_step, more;
  assign lfsr_load = state_q == S_IDLE && start && ena;
  assign lfsr_step = state_q == S_VOTE && ena;
  // eval_q counts launches of the current bit, so it equals NUM_EVAL after the last sample
  assign more      = eval_q != EW'(NUM_EVAL);
  puf_lfsr #(.W(CHAL_W)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(lfsr_load),
    .step_i(lfsr_step),
    .seed_i(challenge_in),
    .lfsr_o(race_challenge)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      idx_q        <= '0;
      race_launch  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      response     <= '0;
      unstable_cnt <= '0;
    end else if (!ena && state_q != S_IDLE) begin
      state_q      <= S_IDLE;
      race_launch  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      response     <= '0;
      unstable_cnt <= '0;
    end else begin
      race_launch <= 1'b0;
      done        <= 1'b0;
      case (state_q)
        S_IDLE: if (start && ena) begin
          state_q      <= S_LOAD;
          busy         <= 1'b1;
          response     <= '0;
          unstable_cnt <= '0;
          idx_q        <= '0;
          ones_q       <= '0;
          eval_q       <= '0;
        end
        S_LOAD: begin
          state_q     <= S_LAUNCH;
          race_launch <= 1'b1;
        end
        S_LAUNCH: begin
          state_q <= S_SETTLE;
          eval_q  <= eval_q + EW'(1);
          cyc_q   <= CW'(1);
        end
        S_SETTLE: if (cyc_q == CW'(SETTLE_CYC)) state_q <= S_SAMPLE;
                  else cyc_q <= cyc_q + CW'(1);
        S_SAMPLE: begin
          ones_q <= ones_q + EW'(race_bit);
          cyc_q  <= CW'(1);
          if (GAP_CYC == 0) begin
            state_q     <= more ? S_LAUNCH : S_VOTE;
            race_launch <= more;
          end else state_q <= S_GAP;
        end
        S_GAP: if (cyc_q == CW'(GAP_CYC)) begin
          state_q     <= more ? S_LAUNCH : S_VOTE;
          race_launch <= more;
        end else cyc_q <= cyc_q + CW'(1);
        S_VOTE: begin
          response[idx_q] <= ones_q > EW'(NUM_EVAL / 2);
          unstable_cnt    <= unstable_cnt + UW'(ones_q != '0 && ones_q != EW'(NUM_EVAL));
          ones_q          <= '0;
          eval_q          <= '0;
          idx_q           <= idx_q + IW'(1);
          state_q         <= idx_q == IW'(RESP_W - 1) ? S_DONE : S_LAUNCH;
          race_launch     <= idx_q != IW'(RESP_W - 1);
          done            <= idx_q == IW'(RESP_W - 1);
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule
